// File: rtl/sb_spram256ka_if.sv
// -----------------------------------------------------------------------------
// sb_spram256ka_if
//   Port bundle for the 16K x 16 single-port SPRAM model. The signal names
//   match the vendor primitive so that user logic reads like the datasheet.
//
//   Parameters:
//     ADDR_W      address width; must match the ADDR_W of the attached RAM.
//
//   Signals:
//     ADDRESS     word address
//     DATAIN      write data (16 bits, four nibbles)
//     MASKWREN    nibble write enables, bit i -> DATAIN[4i+3:4i]
//     WREN        1 = write cycle, 0 = read cycle
//     CHIPSELECT  access enable
//     STANDBY     1 = accesses ignored, DATAOUT holds
//     SLEEP       1 = accesses ignored, DATAOUT forced to 0
//     POWEROFF    active-low power; 0 = accesses ignored, DATAOUT forced to 0
//     DATAOUT     registered read data
//
//   Modports:
//     master      user logic driving the RAM
//     slave       the RAM itself
// -----------------------------------------------------------------------------
interface sb_spram256ka_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] ADDRESS;
  logic [15:0]       DATAIN;
  logic [3:0]        MASKWREN;
  logic              WREN;
  logic              CHIPSELECT;
  logic              STANDBY;
  logic              SLEEP;
  logic              POWEROFF;
  logic [15:0]       DATAOUT;

  modport master (
    output ADDRESS, DATAIN, MASKWREN, WREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF,
    input  DATAOUT
  );

  modport slave (
    input  ADDRESS, DATAIN, MASKWREN, WREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF,
    output DATAOUT
  );
endinterface : sb_spram256ka_if

// File: rtl/sb_spram256ka.sv
// -----------------------------------------------------------------------------
// sb_spram256ka
//   Behavioural model of the 16K x 16 single-port SPRAM macro: synchronous
//   write with per-nibble mask, one-cycle registered read, and the STANDBY /
//   SLEEP / POWEROFF power controls of the vendor primitive. An asynchronous
//   active-low reset clears the output register only; array contents survive.
//
//   Optional feature (compile-time macro SPRAM_INIT_ZERO_EN):
//     defined   - every word starts at 16'h0000, so unwritten words read 0.
//     undefined - the array starts uninitialised (X in simulation).
//
//   Parameters:
//     ADDR_W  address width, depth = 2**ADDR_W words (default 14 -> 16K)
//     DATA_W  word width; fixed at 16 because the mask covers four nibbles
//
//   Ports:
//     clk     rising-edge clock, samples every access
//     rst_n   asynchronous active-low reset, clears DATAOUT
//     bus     sb_spram256ka_if.slave: ADDRESS, DATAIN, MASKWREN, WREN,
//             CHIPSELECT, STANDBY, SLEEP, POWEROFF in; DATAOUT out
// -----------------------------------------------------------------------------
module sb_spram256ka #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  sb_spram256ka_if.slave  bus
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int N_NIB  = DATA_W / 4;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately left out of the reset; clearing 16K words
  // is not something the macro can do, and rst_n is specified to touch only
  // the output register. Zero-start is a declaration initialiser instead.
`ifdef SPRAM_INIT_ZERO_EN
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
`else
  logic [DATA_W-1:0] mem [DEPTH];
`endif

  logic [DATA_W-1:0] dout_q;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  // power_down covers both deep low-power modes; in either one the output is
  // forced to zero and the array is isolated.
  logic power_down;
  logic en;
  logic wr_en;
  logic rd_en;

  assign power_down = bus.SLEEP | ~bus.POWEROFF;
  assign en         = bus.CHIPSELECT & ~bus.STANDBY & ~power_down;
  assign wr_en      = en &  bus.WREN;
  assign rd_en      = en & ~bus.WREN;

  // ---------------------------------------------------------------------------
  // Write port
  // ---------------------------------------------------------------------------
  // Each nibble lane is updated only when its mask bit is set; lanes with a
  // clear bit keep their stored value. MASKWREN == 0 is a legal write cycle
  // that changes nothing. Qualifying with rst_n keeps the array untouched on
  // any edge seen while reset is asserted.
  // NOTE: non-blocking assignment so that a read on the same edge returns the
  // pre-write word, and the read on the following edge sees the new one.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int i = 0; i < N_NIB; i++) begin
        if (bus.MASKWREN[i]) begin
          mem[bus.ADDRESS][4*i +: 4] <= bus.DATAIN[4*i +: 4];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read / output register
  // ---------------------------------------------------------------------------
  // The register loads only on a read cycle, so writes, idle cycles and
  // STANDBY all hold the last read value (no write-through). While powered
  // down the register is cleared on every edge; that is what keeps DATAOUT at
  // zero after SLEEP/POWEROFF is released until a fresh read reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (power_down) begin
      dout_q <= '0;
    end else if (rd_en) begin
      dout_q <= mem[bus.ADDRESS];
    end
  end

  // NOTE: the zero forcing is combinational on SLEEP/POWEROFF so DATAOUT
  // drops immediately when power is removed, without waiting for a clock.
  assign bus.DATAOUT = power_down ? '0 : dout_q;

endmodule : sb_spram256ka

// File: tb/tb_sb_spram256ka.sv
// -----------------------------------------------------------------------------
// tb_sb_spram256ka
//   Directed scoreboard bench for sb_spram256ka. Stimulus tasks drive the bus
//   on the falling edge and push the hand-computed DATAOUT expected at a given
//   cycle; a monitor pops and compares on the falling edge (or immediately,
//   for the asynchronous reset/power-down forcing).
// -----------------------------------------------------------------------------
module tb_sb_spram256ka;

  localparam int ADDR_W = 14;

  logic clk;
  logic rst_n;

  sb_spram256ka_if #(.ADDR_W(ADDR_W)) bus ();

  sb_spram256ka #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter, advanced on every rising edge.
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [15:0] value;
    int          due;
  } exp_t;

  exp_t q[$];
  event check_now;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: DATAOUT=%h expected=%h (t=%0t)", name, got, want, $time);
  endtask

  task automatic expect_at(input string name, input logic [15:0] value, input int due);
    exp_t e;
    e.name  = name;
    e.value = value;
    e.due   = due;
    q.push_back(e);
  endtask

  // Expectation checked right now (used a little after an asynchronous change).
  task automatic expect_now(input string name, input logic [15:0] value);
    expect_at(name, value, cyc);
    ->check_now;
  endtask

  always begin
    @(negedge clk or check_now);
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check(e.name, bus.DATAOUT, e.value);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at a falling edge, return at the next one)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic cs, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [15:0] d, input logic [3:0] m);
    bus.CHIPSELECT = cs;
    bus.WREN       = we;
    bus.ADDRESS    = a;
    bus.DATAIN     = d;
    bus.MASKWREN   = m;
    @(negedge clk);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic [3:0] m);
    drive(1'b1, 1'b1, a, d, m);
  endtask

  // Write cycle whose following output must still show `hold`.
  task automatic wr_hold(input string name, input logic [ADDR_W-1:0] a,
                         input logic [15:0] d, input logic [3:0] m, input logic [15:0] hold);
    expect_at(name, hold, cyc + 1);
    drive(1'b1, 1'b1, a, d, m);
  endtask

  task automatic rd(input string name, input logic [ADDR_W-1:0] a, input logic [15:0] want);
    expect_at(name, want, cyc + 1);
    drive(1'b1, 1'b0, a, 16'h0000, 4'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n          = 1'b0;
    bus.ADDRESS    = '0;
    bus.DATAIN     = '0;
    bus.MASKWREN   = '0;
    bus.WREN       = 1'b0;
    bus.CHIPSELECT = 1'b0;
    bus.STANDBY    = 1'b0;
    bus.SLEEP      = 1'b0;
    bus.POWEROFF   = 1'b1;

    repeat (2) @(negedge clk);
    #1 expect_now("reset_dout", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-word writes, then reads with one-cycle latency.
    wr(0, 16'h0001, 4'hF);
    wr(1, 16'h0002, 4'hF);
    wr(2, 16'h0004, 4'hF);
    wr(3, 16'h0007, 4'hF);
    rd("rd_addr0", 0, 16'h0001);
    rd("rd_addr1", 1, 16'h0002);
    rd("rd_addr2", 2, 16'h0004);
    rd("rd_addr3", 3, 16'h0007);

    // Nibble mask: lanes 0 and 2 take 1234, lanes 1 and 3 keep F.
    wr(5, 16'hFFFF, 4'hF);
    wr(5, 16'h1234, 4'b0101);
    rd("mask_0101", 5, 16'hF2F4);

    // No write-through, and an all-zero mask changes nothing.
    rd("rd0_before_wr", 0, 16'h0001);
    wr_hold("hold_on_write", 0, 16'hABCD, 4'hF, 16'h0001);
    rd("raw_addr0", 0, 16'hABCD);
    wr_hold("hold_mask0", 0, 16'h1111, 4'h0, 16'hABCD);
    rd("mask0_nochange", 0, 16'hABCD);

    // STANDBY blocks the write and holds the output.
    bus.STANDBY = 1'b1;
    wr_hold("standby_hold", 1, 16'h5555, 4'hF, 16'hABCD);
    bus.STANDBY = 1'b0;
    rd("standby_no_write", 1, 16'h0002);

    // Idle (CHIPSELECT low) with WREN high does not write.
    drive(1'b0, 1'b1, 1, 16'h7777, 4'hF);
    rd("idle_no_write", 1, 16'h0002);

    // SLEEP: immediate zero, write ignored, stays zero after exit until a read.
    bus.SLEEP = 1'b1;
    #1 expect_now("sleep_immediate", 16'h0000);
    wr_hold("sleep_write_out", 2, 16'h9999, 4'hF, 16'h0000);
    bus.SLEEP = 1'b0;
    #1 expect_now("sleep_exit_zero", 16'h0000);
    rd("sleep_no_write", 2, 16'h0004);

    // POWEROFF: same behaviour.
    bus.POWEROFF = 1'b0;
    #1 expect_now("poweroff_immediate", 16'h0000);
    wr_hold("poweroff_write_out", 2, 16'h9999, 4'hF, 16'h0000);
    bus.POWEROFF = 1'b1;
    rd("poweroff_no_write", 2, 16'h0004);

    // Asynchronous reset mid-cycle; a write attempted under reset is dropped.
    rd("rd3_before_reset", 3, 16'h0007);
    #1 rst_n = 1'b0;
    #1 expect_now("async_reset", 16'h0000);
    @(negedge clk);
    wr(3, 16'h1111, 4'hF);
    rst_n = 1'b1;
    rd("rd3_after_reset", 3, 16'h0007);

    // Address boundaries.
    wr(16383, 16'hBEEF, 4'hF);
    wr(0, 16'hCAFE, 4'hF);
    rd("rd_top_addr", 16383, 16'hBEEF);
    rd("rd_addr0_cafe", 0, 16'hCAFE);
`ifdef SPRAM_INIT_ZERO_EN
    rd("rd_unwritten", 100, 16'h0000);
`endif
    drive(1'b0, 1'b0, 0, 16'h0000, 4'h0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      $display("FAIL %s: never compared (timeout) expected=%h", e.name, e.value);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sb_spram256ka

// File: doc/sb_spram256ka.md
Name: sb_spram256ka

Overview:
- Behavioural model of the 16K x 16 single-port SPRAM macro: synchronous write with per-nibble write mask, registered read, and power-control inputs.
- Instantiated directly by user logic, e.g. LED colour tables, as a 256 Kbit scratch memory clocked from the system clock.
- Provides the same port behaviour as the vendor primitive, plus an asynchronous active-low reset on the output register.

Parameters:
- ADDR_W, 14, address width; depth is 2**ADDR_W words.
- DATA_W, 16, word width; fixed at 16 because the mask is 4 nibbles.

Ports:
- clk  input  1  clock; all accesses are sampled on the rising edge.
- rst_n  input  1  asynchronous active-low reset; clears DATAOUT only.
- ADDRESS  input  ADDR_W  word address; if a wider value is connected, the upper bits are ignored.
- DATAIN  input  16  write data.
- MASKWREN  input  4  nibble write enables; bit i enables DATAIN[4i+3:4i].
- WREN  input  1  1 = write cycle, 0 = read cycle.
- CHIPSELECT  input  1  access enable.
- STANDBY  input  1  1 = no accesses, output holds.
- SLEEP  input  1  1 = no accesses, output forced 0.
- POWEROFF  input  1  active-low power; 0 = off, no accesses, output forced 0.
- DATAOUT  output  16  registered read data.

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous and active-low.
- Reset: while rst_n=0, DATAOUT=16'h0000 immediately, and no read or write occurs on any edge. Memory contents are not altered by reset.
- Access enable: en = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF.
- Write, on the rising clk edge when en & WREN:
  - For each i in 0..3 with MASKWREN[i]=1, mem[ADDRESS][4i+3:4i] <= DATAIN[4i+3:4i].
  - Nibbles whose mask bit is 0 keep their old value.
  - DATAOUT holds its previous value during a write (no write-through).
- Read, on the rising clk edge when en & ~WREN:
  - DATAOUT <= mem[ADDRESS].
  - Latency is 1 clock from the edge that samples ADDRESS.
  - A user that registers the address itself sees data 2 clocks after driving it.
- Read-after-write: a read of the same address on the edge after a write returns the newly written data, respecting the mask.
- Idle: CHIPSELECT=0 with all power controls inactive leaves memory unchanged and DATAOUT holding.
- STANDBY=1, SLEEP=0, POWEROFF=1: accesses are ignored and DATAOUT holds.
- SLEEP=1 or POWEROFF=0:
  - Accesses are ignored and DATAOUT is 0.
  - The forcing is combinational on these inputs, regardless of clk.
  - The memory array retains its contents; no random corruption is modelled.
- Exit from SLEEP/POWEROFF: DATAOUT stays 0 until the next read cycle updates it.
- Address range: addresses 0 .. 2**ADDR_W-1 are all valid. There is no wrap logic beyond truncation of wider address inputs.
- MASKWREN=4'b0000 with WREN=1: this is a write cycle that changes nothing; DATAOUT holds.
- Simultaneous rst_n deassertion and a clock edge: the access on that edge is ignored.

Optional Feature:
- Macro SPRAM_INIT_ZERO_EN.
- Defined: every memory word is initialised to 16'h0000 at time zero, so reads before any write return 0.
- Undefined: the memory is not initialised, and reads of never-written words return X in simulation.
- DATAOUT reset behaviour is identical in both cases.

Test Plan:
- Write sequence: write addresses 0..3 with 16'h0001, 16'h0002, 16'h0004, 16'h0007 (MASKWREN=4'hF, CHIPSELECT=1, POWEROFF=1), then read 0..3 -> DATAOUT shows each value 1 clock after its address edge; addresses 0 and 3 read 16'h0001 and 16'h0007.
- Nibble mask: write 16'hFFFF to address 5, then write 16'h1234 with MASKWREN=4'b0101, then read address 5 -> 16'hF2F4.
- Hold and standby:
  - Read address 0 -> 16'h0001.
  - Then write 16'hABCD to address 0 -> DATAOUT still 16'h0001 in the cycle after the write.
  - With STANDBY=1, attempt a write of 16'h5555 to address 1, then read address 1 after STANDBY=0 -> 16'h0002.
- Sleep/poweroff:
  - SLEEP=1 -> DATAOUT=0 immediately; a write of 16'h9999 to address 2 during sleep is ignored.
  - After SLEEP=0, read address 2 -> 16'h0004. Repeat the check with POWEROFF=0.
- Reset mid-operation: assert rst_n=0 between clock edges while DATAOUT=16'h0007 -> DATAOUT=0 without waiting for a clock; after release, read address 3 -> 16'h0007.
- Boundaries: write 16'hBEEF to address 16383 and 16'hCAFE to address 0 -> both read back intact. Read a never-written address with SPRAM_INIT_ZERO_EN defined -> 16'h0000.
